// File: rtl/traffic_light_checker.sv
// Lamp-sequence checker for the traffic_light controller: tracks the current phase, enforces
// legal lamp combinations, phase order and exact dwell times, and counts clean full sequences.
module traffic_light_checker #(
  parameter int RED_T    = 6,
  parameter int REDYLW_T = 2,
  parameter int GREEN_T  = 6,
  parameter int YELLOW_T = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             err_combo,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             fault,
  output logic [15:0]      cycles_done
);

  typedef enum logic [2:0] {
    PH_SYNC   = 3'd0,
    PH_RED    = 3'd1,
    PH_REDYLW = 3'd2,
    PH_GREEN  = 3'd3,
    PH_YELLOW = 3'd4
  } phase_t;

  localparam logic [CNT_W-1:0] DW_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_RED    = CNT_W'(RED_T);
  localparam logic [CNT_W-1:0] T_REDYLW = CNT_W'(REDYLW_T);
  localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_T);

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             clean_q, clean_d;
  logic             err_combo_q, err_combo_d;
  logic             err_seq_q, err_seq_d;
  logic             err_dwell_q, err_dwell_d;
  logic             fault_q, fault_d;
  logic [15:0]      cycles_q, cycles_d;

  logic [2:0]       combo;
  phase_t           combo_ph;
  logic             combo_legal;
  phase_t           exp_next;
  logic [CNT_W-1:0] cur_t;
  logic [CNT_W-1:0] dwell_inc;
  logic             short_exit;

  assign combo = {red, yellow, green};

  always_comb begin
    combo_ph    = PH_SYNC;
    combo_legal = 1'b1;
    case (combo)
      3'b100:  combo_ph = PH_RED;
      3'b110:  combo_ph = PH_REDYLW;
      3'b001:  combo_ph = PH_GREEN;
      3'b010:  combo_ph = PH_YELLOW;
      default: combo_legal = 1'b0;
    endcase
  end

  always_comb begin
    exp_next = PH_RED;
    cur_t    = '0;
    case (phase_q)
      PH_RED:    begin exp_next = PH_REDYLW; cur_t = T_RED;    end
      PH_REDYLW: begin exp_next = PH_GREEN;  cur_t = T_REDYLW; end
      PH_GREEN:  begin exp_next = PH_YELLOW; cur_t = T_GREEN;  end
      PH_YELLOW: begin exp_next = PH_RED;    cur_t = T_YELLOW; end
      default:   begin exp_next = PH_RED;    cur_t = '0;       end
    endcase
  end

  // Dwell saturates so a stuck lamp never wraps back into the legal window.
  assign dwell_inc  = (&dwell_q) ? dwell_q : dwell_q + DW_ONE;
  assign short_exit = (dwell_q < cur_t);

  always_comb begin
    phase_d     = phase_q;
    dwell_d     = dwell_q;
    clean_d     = clean_q;
    cycles_d    = cycles_q;
    err_combo_d = 1'b0;
    err_seq_d   = 1'b0;
    err_dwell_d = 1'b0;
    if (!combo_legal) begin
      err_combo_d = 1'b1;
      phase_d     = PH_SYNC;
      dwell_d     = '0;
      clean_d     = 1'b0;
    end else if (phase_q == PH_SYNC) begin
      if (combo_ph == PH_RED) begin
        phase_d = PH_RED;
        dwell_d = DW_ONE;
        clean_d = 1'b1;
      end
    end else if (combo_ph == phase_q) begin
      dwell_d = dwell_inc;
      // Overstay is flagged exactly once, on the first cycle past the limit.
      if (dwell_inc == cur_t + DW_ONE) begin
        err_dwell_d = 1'b1;
        clean_d     = 1'b0;
      end
    end else if (combo_ph == exp_next) begin
      err_dwell_d = short_exit;
      phase_d     = combo_ph;
      dwell_d     = DW_ONE;
      if (phase_q == PH_YELLOW) begin
        if (clean_q && !short_exit) begin
          cycles_d = cycles_q + 16'd1;
        end
        clean_d = 1'b1;
      end else begin
        clean_d = clean_q && !short_exit;
      end
    end else begin
      err_seq_d = 1'b1;
      phase_d   = combo_ph;
      dwell_d   = DW_ONE;
      clean_d   = (combo_ph == PH_RED);
    end
    fault_d = fault_q | err_combo_d | err_seq_d | err_dwell_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q     <= PH_SYNC;
      dwell_q     <= '0;
      clean_q     <= 1'b0;
      err_combo_q <= 1'b0;
      err_seq_q   <= 1'b0;
      err_dwell_q <= 1'b0;
      fault_q     <= 1'b0;
      cycles_q    <= '0;
    end else begin
      phase_q     <= phase_d;
      dwell_q     <= dwell_d;
      clean_q     <= clean_d;
      err_combo_q <= err_combo_d;
      err_seq_q   <= err_seq_d;
      err_dwell_q <= err_dwell_d;
      fault_q     <= fault_d;
      cycles_q    <= cycles_d;
    end
  end

  assign phase       = phase_q;
  assign dwell       = dwell_q;
  assign err_combo   = err_combo_q;
  assign err_seq     = err_seq_q;
  assign err_dwell   = err_dwell_q;
  assign fault       = fault_q;
  assign cycles_done = cycles_q;

endmodule

// File: tb/tb_traffic_light_checker.sv
// Bench for traffic_light_checker: vector table, hand-written corner sequences and a
// randomized run scored against an arithmetic model of the lamp rules.
module tb_traffic_light_checker;

  localparam int CNT_W  = 8;
  localparam int DW_MAX = (1 << CNT_W) - 1;
  localparam int W      = 31;

  logic             clk;
  logic             rst;
  logic             red, yellow, green;
  logic [2:0]       phase;
  logic [CNT_W-1:0] dwell;
  logic             err_combo, err_seq, err_dwell, fault;
  logic [15:0]      cycles_done;

  traffic_light_checker #(
    .RED_T(6), .REDYLW_T(2), .GREEN_T(6), .YELLOW_T(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
    .phase(phase), .dwell(dwell), .err_combo(err_combo), .err_seq(err_seq),
    .err_dwell(err_dwell), .fault(fault), .cycles_done(cycles_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_vec;
  int miscompares;

  typedef struct {
    logic [2:0]  combo;
    logic [2:0]  ph;
    int          dw;
    logic [2:0]  err;
    int          cyc;
    logic        flt;
  } vec_t;
  vec_t vecs[$];

  // ---------------- reference model ----------------
  logic [2:0] ph_combo [5] = '{3'b000, 3'b100, 3'b110, 3'b001, 3'b010};
  int         ph_time  [5] = '{0, 6, 2, 6, 2};
  int m_ph, m_dw, m_cyc;
  bit m_clean, m_fault, e_c, e_s, e_d;

  function automatic int lookup(input logic [2:0] c);
    for (int k = 1; k <= 4; k++) if (ph_combo[k] == c) return k;
    return 0;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_dw = 0; m_cyc = 0; m_clean = 0; m_fault = 0;
    e_c = 0; e_s = 0; e_d = 0;
  endtask

  task automatic model_step(input logic [2:0] c);
    int p;
    p = lookup(c);
    e_c = 0; e_s = 0; e_d = 0;
    if (p == 0) begin
      e_c = 1; m_ph = 0; m_dw = 0; m_clean = 0;
    end else if (m_ph == 0) begin
      if (p == 1) begin m_ph = 1; m_dw = 1; m_clean = 1; end
    end else if (p == m_ph) begin
      m_dw = (m_dw + 1 > DW_MAX) ? DW_MAX : m_dw + 1;
      if (m_dw == ph_time[m_ph] + 1) begin e_d = 1; m_clean = 0; end
    end else if (p == (m_ph % 4) + 1) begin
      if (m_dw < ph_time[m_ph]) begin e_d = 1; m_clean = 0; end
      if (p == 1) begin
        if (m_clean) m_cyc = (m_cyc + 1) % 65536;
        m_clean = 1;
      end
      m_ph = p; m_dw = 1;
    end else begin
      e_s = 1; m_ph = p; m_dw = 1; m_clean = (p == 1);
    end
    if (e_c || e_s || e_d) m_fault = 1;
  endtask

  function automatic logic [W-1:0] pack(input int ph, input int dw, input logic [2:0] err,
                                        input logic flt, input int cyc);
    return {ph[2:0], dw[7:0], err, flt, cyc[15:0]};
  endfunction

  function automatic logic [W-1:0] model_word();
    return pack(m_ph, m_dw, {e_c, e_s, e_d}, m_fault, m_cyc);
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {phase, dwell, err_combo, err_seq, err_dwell, fault, cycles_done};
  endfunction

  function automatic string fmt(input logic [W-1:0] w);
    return $sformatf("ph=%0d dw=%0d err(c,s,d)=%b fault=%b cyc=%0d",
                     w[30:28], w[27:20], w[19:17], w[16], w[15:0]);
  endfunction

  task automatic check_word(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = dut_word();
    n_vec++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %s, want %s", name, $time, fmt(act), fmt(exp));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] c, input string name);
    {red, yellow, green} = c;
    @(posedge clk);
    model_step(c);
    exp_q.push_back(model_word());
    #1;
    check_word(name, exp_q.pop_front());
  endtask

  task automatic drive_n(input logic [2:0] c, input int n, input string name);
    for (int k = 0; k < n; k++) drive(c, name);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    {red, yellow, green} = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    check_word("reset_hold", '0);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic clean_seq(input string name);
    drive_n(3'b100, 6, name);
    drive_n(3'b110, 2, name);
    drive_n(3'b001, 6, name);
    drive_n(3'b010, 2, name);
  endtask

  task automatic add(input logic [2:0] c, input logic [2:0] ph, input int dw,
                     input logic [2:0] err, input int cyc, input logic flt);
    vec_t v;
    v.combo = c; v.ph = ph; v.dw = dw; v.err = err; v.cyc = cyc; v.flt = flt;
    vecs.push_back(v);
  endtask

  localparam logic [2:0] E_C = 3'b100, E_S = 3'b010, E_D = 3'b001;

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] illegal [4] = '{3'b000, 3'b011, 3'b101, 3'b111};
    int gi, len, r, k, n_rand;

    n_vec = 0; miscompares = 0;
    rst = 1'b0; {red, yellow, green} = 3'b000;
    model_reset();

    // Vector table: clean sequence, overstay, illegal combo, short RED, recount.
    for (int i = 1; i <= 6; i++) add(3'b100, 1, i, 0, 0, 0);
    for (int i = 1; i <= 2; i++) add(3'b110, 2, i, 0, 0, 0);
    for (int i = 1; i <= 6; i++) add(3'b001, 3, i, 0, 0, 0);
    for (int i = 1; i <= 2; i++) add(3'b010, 4, i, 0, 0, 0);
    add(3'b100, 1, 1, 0, 1, 0);
    for (int i = 2; i <= 6; i++) add(3'b100, 1, i, 0, 1, 0);
    for (int i = 1; i <= 2; i++) add(3'b110, 2, i, 0, 1, 0);
    for (int i = 1; i <= 6; i++) add(3'b001, 3, i, 0, 1, 0);
    add(3'b001, 3, 7, E_D, 1, 1);
    add(3'b010, 4, 1, 0, 1, 1);
    add(3'b010, 4, 2, 0, 1, 1);
    add(3'b100, 1, 1, 0, 1, 1);
    add(3'b111, 0, 0, E_C, 1, 1);
    add(3'b010, 0, 0, 0, 1, 1);
    add(3'b100, 1, 1, 0, 1, 1);
    for (int i = 2; i <= 5; i++) add(3'b100, 1, i, 0, 1, 1);
    add(3'b110, 2, 1, E_D, 1, 1);
    add(3'b110, 2, 2, 0, 1, 1);
    for (int i = 1; i <= 6; i++) add(3'b001, 3, i, 0, 1, 1);
    for (int i = 1; i <= 2; i++) add(3'b010, 4, i, 0, 1, 1);
    add(3'b100, 1, 1, 0, 1, 1);
    for (int i = 2; i <= 6; i++) add(3'b100, 1, i, 0, 1, 1);
    for (int i = 1; i <= 2; i++) add(3'b110, 2, i, 0, 1, 1);
    for (int i = 1; i <= 6; i++) add(3'b001, 3, i, 0, 1, 1);
    for (int i = 1; i <= 2; i++) add(3'b010, 4, i, 0, 1, 1);
    add(3'b100, 1, 1, 0, 2, 1);

    // Reset held while RED is driven, then release: first sample lands in RED.
    apply_reset();
    foreach (vecs[i]) begin
      {red, yellow, green} = vecs[i].combo;
      @(posedge clk);
      #1;
      check_word($sformatf("table[%0d]", i),
                 pack(vecs[i].ph, vecs[i].dw, vecs[i].err, vecs[i].flt, vecs[i].cyc));
    end

    // Three clean sequences count to 3 with no fault.
    apply_reset();
    clean_seq("clean1"); clean_seq("clean2"); clean_seq("clean3");
    drive(3'b100, "clean_end");
    check_word("clean_x3", pack(1, 1, 0, 0, 3));

    // Order error: RED then GREEN.
    apply_reset();
    drive_n(3'b100, 6, "order_red");
    drive(3'b001, "order_green");
    check_word("order_err", pack(3, 1, E_S, 1, 0));
    drive_n(3'b001, 5, "order_green_rest");
    drive_n(3'b010, 2, "order_yellow");
    drive(3'b100, "order_red_again");
    check_word("order_not_counted", pack(1, 1, 0, 1, 0));

    // Stuck GREEN: one overstay pulse, dwell saturates.
    apply_reset();
    drive(3'b100, "sat_red");
    drive_n(3'b110, 2, "sat_ry");
    drive_n(3'b001, 270, "sat_green");
    check_word("sat_dwell", pack(3, DW_MAX, 0, 1, 0));

    // Asynchronous reset between edges mid-GREEN with non-zero state.
    apply_reset();
    clean_seq("async_a");
    drive(3'b111, "async_bad");
    drive(3'b100, "async_red");
    drive_n(3'b100, 5, "async_red2");
    drive_n(3'b110, 2, "async_ry");
    drive_n(3'b001, 3, "async_green");
    #3 rst = 1'b0;
    #1;
    check_word("async_clear", '0);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    drive(3'b100, "async_after");

    // Randomized run against the model.
    apply_reset();
    gi = 1; n_rand = 0;
    while (n_rand < 3000) begin
      r = $urandom_range(0, 19);
      if (r < 15) begin
        len = ph_time[gi];
        k = $urandom_range(0, 7);
        if (k == 0 && len > 1) len--;
        else if (k == 1) len++;
        drive_n(ph_combo[gi], len, "rand_seq");
        n_rand += len;
        gi = (gi % 4) + 1;
      end else if (r < 17) begin
        k = $urandom_range(1, 4);
        len = $urandom_range(1, 3);
        drive_n(ph_combo[k], len, "rand_jump");
        n_rand += len;
        gi = (k % 4) + 1;
      end else if (r < 19) begin
        drive(illegal[$urandom_range(0, 3)], "rand_illegal");
        n_rand++;
        gi = 1;
      end else begin
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) drive(3'($urandom_range(0, 7)), "rand_any");
        n_rand += len;
        gi = 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
